// File: rtl/led_place_8x8_pkg.sv
// Shared geometry and frame bit-mapping for the 8x8 LED matrix blocks.
// The scanner uses the same mapping, so keep frame_bit_idx in sync with it.
package led_place_8x8_pkg;

    localparam int LP_ROWS    = 8;
    localparam int LP_COLS    = 8;
    localparam int LP_FRAME_W = 64;

    typedef logic [LP_ROWS-1:0]    col_byte_t;
    typedef logic [LP_FRAME_W-1:0] frame_t;

    function automatic int frame_bit_idx(input int row, input int col);
        return LP_COLS * row + col;
    endfunction

endpackage

// File: rtl/led_place_col_fifo.sv
// Small column-byte FIFO with level tracking, registered ready, and
// asynchronous head read so a pop can consume the head in the same cycle.
module led_place_col_fifo #(
    parameter int P_DEPTH = 8,
    parameter int P_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr_i,
    input  logic                       push_i,
    input  logic [P_WIDTH-1:0]         data_i,
    input  logic                       pop_i,
    output logic [P_WIDTH-1:0]         head_o,
    output logic [$clog2(P_DEPTH):0]   level_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic                       ready_o
);

    localparam int AW = $clog2(P_DEPTH);
    localparam logic [AW:0]   LVL_MAX = (AW+1)'(P_DEPTH);
    localparam logic [AW:0]   LVL_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [P_WIDTH-1:0] mem_q [P_DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [AW:0]        level_q, level_d;
    logic               ready_q, ready_d;
    logic               do_push, do_pop;

    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == LVL_MAX);
    assign level_o = level_q;
    assign ready_o = ready_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o && !clr_i;
    assign do_pop  = pop_i && !empty_o && !clr_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   level_d = level_q + LVL_ONE;
                2'b01:   level_d = level_q - LVL_ONE;
                default: level_d = level_q;
            endcase
        end
        ready_d = (level_d < LVL_MAX);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ready_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ready_q  <= ready_d;
        end
    end

    // Storage carries no reset; stale entries are never visible past the level count.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/led_place_8x8_scroller.sv
// Marquee source for the 8x8 scanner: queues column bytes and, at a
// programmable rate, shifts the frame left inserting the next column at col 7.
module led_place_8x8_scroller
    import led_place_8x8_pkg::*;
#(
    parameter int P_FIFO_DEPTH = 8,
    parameter int P_DIV_WIDTH  = 24
) (
    input  logic                            aclk,
    input  logic                            areset,
    input  logic [7:0]                      s_col_data,
    input  logic                            s_col_valid,
    output logic                            s_col_ready,
    input  logic                            i_scroll_en,
    input  logic [P_DIV_WIDTH-1:0]          i_scroll_div,
    input  logic                            i_clear,
    output logic [63:0]                     o_led_data,
    output logic                            o_frame_update,
    output logic [$clog2(P_FIFO_DEPTH):0]   o_fifo_level,
    output logic                            o_underrun
);

    localparam logic [P_DIV_WIDTH-1:0] DIV_ONE = P_DIV_WIDTH'(1);

    logic [P_DIV_WIDTH-1:0] div_q, div_d;
    frame_t                 frame_q, frame_d;
    frame_t                 shifted_frame;
    logic                   update_q, update_d;
    logic                   underrun_q, underrun_d;
    logic                   tick;
    logic                   fifo_push, fifo_pop;
    logic                   fifo_full, fifo_empty;
    col_byte_t              fifo_head;

    assign tick      = i_scroll_en && (div_q == i_scroll_div);
    assign fifo_push = s_col_valid && !fifo_full && !i_clear;
    assign fifo_pop  = tick && !i_clear;

    led_place_col_fifo #(
        .P_DEPTH (P_FIFO_DEPTH),
        .P_WIDTH (LP_ROWS)
    ) u_col_fifo (
        .clk     (aclk),
        .rst     (areset),
        .clr_i   (i_clear),
        .push_i  (fifo_push),
        .data_i  (s_col_data),
        .pop_i   (fifo_pop),
        .head_o  (fifo_head),
        .level_o (o_fifo_level),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .ready_o (s_col_ready)
    );

    // Column c takes column c+1; the FIFO head (or zeros on underrun) enters at column 7.
    for (genvar gi = 0; gi < LP_ROWS; gi++) begin : g_row
        for (genvar gj = 0; gj < LP_COLS - 1; gj++) begin : g_col
            assign shifted_frame[frame_bit_idx(gi, gj)] = frame_q[frame_bit_idx(gi, gj + 1)];
        end
        assign shifted_frame[frame_bit_idx(gi, LP_COLS - 1)] = fifo_empty ? 1'b0 : fifo_head[gi];
    end

    always_comb begin
        div_d      = div_q;
        frame_d    = frame_q;
        update_d   = 1'b0;
        underrun_d = 1'b0;
        if (i_clear) begin
            div_d   = '0;
            frame_d = '0;
        end else begin
            if (i_scroll_en) div_d = tick ? '0 : div_q + DIV_ONE;
            if (tick) begin
                frame_d    = shifted_frame;
                update_d   = 1'b1;
                underrun_d = fifo_empty;
            end
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            div_q      <= '0;
            frame_q    <= '0;
            update_q   <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            div_q      <= div_d;
            frame_q    <= frame_d;
            update_q   <= update_d;
            underrun_q <= underrun_d;
        end
    end

    assign o_led_data     = frame_q;
    assign o_frame_update = update_q;
    assign o_underrun     = underrun_q;

endmodule

// File: tb/tb_led_place_8x8_scroller.sv
// Scoreboard bench: a column-list model predicts each scroll step's frame and
// underrun flag; a negedge monitor compares them whenever the DUT pulses an update.
module tb_led_place_8x8_scroller;

    localparam int DEPTH = 8;
    localparam int DW    = 24;

    logic          aclk = 1'b0;
    logic          areset = 1'b1;
    logic [7:0]    s_col_data = '0;
    logic          s_col_valid = 1'b0;
    logic          s_col_ready;
    logic          i_scroll_en = 1'b0;
    logic [DW-1:0] i_scroll_div = '0;
    logic          i_clear = 1'b0;
    logic [63:0]   o_led_data;
    logic          o_frame_update;
    logic [3:0]    o_fifo_level;
    logic          o_underrun;

    int checks = 0;
    int failures = 0;
    int updates_seen = 0;

    // Reference model: a queue of pending column bytes, the eight displayed
    // columns, and the number of enabled cycles since the last scroll step.
    logic [7:0]    q_m [$];
    logic [7:0]    cols_m [8];
    logic [DW-1:0] cnt_m;

    logic [63:0] exp_frame_q [$];
    bit          exp_ur_q [$];

    led_place_8x8_scroller #(
        .P_FIFO_DEPTH (DEPTH),
        .P_DIV_WIDTH  (DW)
    ) dut (
        .aclk           (aclk),
        .areset         (areset),
        .s_col_data     (s_col_data),
        .s_col_valid    (s_col_valid),
        .s_col_ready    (s_col_ready),
        .i_scroll_en    (i_scroll_en),
        .i_scroll_div   (i_scroll_div),
        .i_clear        (i_clear),
        .o_led_data     (o_led_data),
        .o_frame_update (o_frame_update),
        .o_fifo_level   (o_fifo_level),
        .o_underrun     (o_underrun)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model_frame();
        logic [63:0] f;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                f[8*r + c] = cols_m[c][r];
        return f;
    endfunction

    task automatic model_reset();
        q_m.delete();
        for (int c = 0; c < 8; c++) cols_m[c] = 8'h00;
        cnt_m = '0;
    endtask

    // Evaluate one rising edge in the model with the current inputs, then
    // advance the DUT and check level/ready just after the edge.
    task automatic cycle();
        bit tick, push, ur;
        logic [7:0] nb;
        tick = i_scroll_en && (cnt_m == i_scroll_div);
        push = s_col_valid && (q_m.size() < DEPTH);
        if (i_clear) begin
            model_reset();
        end else begin
            if (i_scroll_en) cnt_m = tick ? '0 : cnt_m + 1'b1;
            if (tick) begin
                ur = (q_m.size() == 0);
                nb = ur ? 8'h00 : q_m.pop_front();
                for (int c = 0; c < 7; c++) cols_m[c] = cols_m[c+1];
                cols_m[7] = nb;
                exp_frame_q.push_back(model_frame());
                exp_ur_q.push_back(ur);
            end
            if (push) q_m.push_back(s_col_data);
        end
        @(posedge aclk);
        #1;
        chk("fifo_level", 64'(o_fifo_level), 64'(q_m.size()));
        chk("col_ready", 64'(s_col_ready), 64'(q_m.size() < DEPTH));
    endtask

    always @(negedge aclk) begin
        if (!areset) begin
            if (o_frame_update) begin
                updates_seen++;
                $display("update %0d: led=%h underrun=%b level=%0d", updates_seen, o_led_data, o_underrun, o_fifo_level);
                if (exp_frame_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_update actual=1 expected=0");
                end else begin
                    chk("frame", o_led_data, exp_frame_q.pop_front());
                    chk("underrun", 64'(o_underrun), 64'(exp_ur_q.pop_front()));
                end
            end else if (o_underrun) begin
                checks++;
                failures++;
                $display("FAIL lone_underrun actual=1 expected=0");
            end
        end
    end

    initial begin
        int k;
        model_reset();
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        areset = 1'b0;
        chk("rst_led", o_led_data, 64'h0);
        chk("rst_ready", 64'(s_col_ready), 64'h1);
        chk("rst_level", 64'(o_fifo_level), 64'h0);
        chk("rst_update", 64'(o_frame_update), 64'h0);
        chk("rst_underrun", 64'(o_underrun), 64'h0);

        // First tick lands on the 4th enabled edge with div=3.
        s_col_data = 8'hFF; s_col_valid = 1'b1; i_scroll_div = 24'd3; i_scroll_en = 1'b1;
        cycle();
        s_col_valid = 1'b0;
        cycle(); cycle();
        chk("t1_no_early_update", 64'(o_frame_update), 64'h0);
        cycle();
        chk("t1_update", 64'(o_frame_update), 64'h1);
        chk("t1_led", o_led_data, 64'h8080808080808080);
        i_scroll_en = 1'b0;
        cycle();
        chk("t1_single_pulse", 64'(o_frame_update), 64'h0);

        // Diagonal fill.
        i_clear = 1'b1; cycle(); i_clear = 1'b0;
        s_col_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            s_col_data = 8'(1 << i);
            cycle();
        end
        s_col_valid = 1'b0;
        i_scroll_div = '0; i_scroll_en = 1'b1;
        repeat (8) cycle();
        i_scroll_en = 1'b0;
        cycle();
        chk("diag_led", o_led_data, 64'h8040201008040201);

        // Fill to full with scrolling off, then one tick while valid stays high.
        s_col_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            s_col_data = 8'($urandom);
            cycle();
        end
        chk("full_level", 64'(o_fifo_level), 64'd8);
        chk("full_ready", 64'(s_col_ready), 64'h0);
        i_scroll_en = 1'b1;
        cycle();
        i_scroll_en = 1'b0;
        chk("pop_full_level", 64'(o_fifo_level), 64'd7);
        chk("pop_full_ready", 64'(s_col_ready), 64'h1);
        cycle();
        chk("refill_level", 64'(o_fifo_level), 64'd8);
        s_col_valid = 1'b0;

        // All-ones frame, then an underrun step.
        i_clear = 1'b1; cycle(); i_clear = 1'b0;
        s_col_data = 8'hFF; s_col_valid = 1'b1;
        repeat (8) cycle();
        s_col_valid = 1'b0; i_scroll_en = 1'b1;
        repeat (8) cycle();
        cycle();
        chk("ur_led", o_led_data, 64'h7F7F7F7F7F7F7F7F);
        chk("ur_pulse", 64'(o_underrun), 64'h1);
        i_scroll_en = 1'b0;
        cycle();
        chk("ur_pulse_end", 64'(o_underrun), 64'h0);

        // Clear beats a simultaneous push and tick.
        s_col_data = 8'h5A; s_col_valid = 1'b1;
        repeat (3) cycle();
        chk("pre_clear_level", 64'(o_fifo_level), 64'd3);
        i_scroll_en = 1'b1; i_clear = 1'b1;
        cycle();
        i_clear = 1'b0; s_col_valid = 1'b0; i_scroll_en = 1'b0;
        chk("clr_level", 64'(o_fifo_level), 64'd0);
        chk("clr_led", o_led_data, 64'h0);
        chk("clr_update", 64'(o_frame_update), 64'h0);
        chk("clr_underrun", 64'(o_underrun), 64'h0);

        // Pausing the enable for 10 cycles delays the tick by exactly 10.
        i_scroll_div = 24'd5; i_scroll_en = 1'b1;
        s_col_data = 8'hC3; s_col_valid = 1'b1;
        cycle();
        s_col_valid = 1'b0;
        cycle(); cycle();
        i_scroll_en = 1'b0;
        repeat (10) cycle();
        i_scroll_en = 1'b1;
        k = 21;
        for (int i = 1; i <= 20; i++) begin
            cycle();
            if (o_frame_update) begin
                k = i;
                break;
            end
        end
        chk("pause_tick_cycle", 64'(k), 64'd3);
        i_scroll_en = 1'b0;

        // Random traffic with a fixed divider per run.
        i_clear = 1'b1; cycle(); i_clear = 1'b0;
        i_scroll_div = DW'($urandom_range(0, 3));
        for (int i = 0; i < 400; i++) begin
            s_col_data  = 8'($urandom);
            s_col_valid = ($urandom_range(0, 99) < 60);
            i_scroll_en = ($urandom_range(0, 99) < 70);
            i_clear     = ($urandom_range(0, 99) < 3);
            cycle();
        end
        i_clear = 1'b0; s_col_valid = 1'b0; i_scroll_en = 1'b0;
        repeat (2) cycle();

        // Asynchronous reset mid-scroll.
        i_scroll_div = '0; i_scroll_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            s_col_data  = 8'($urandom);
            s_col_valid = 1'b1;
            cycle();
        end
        @(negedge aclk);
        #1;
        areset = 1'b1;
        #1;
        chk("arst_led", o_led_data, 64'h0);
        chk("arst_ready", 64'(s_col_ready), 64'h1);
        chk("arst_level", 64'(o_fifo_level), 64'h0);
        chk("arst_update", 64'(o_frame_update), 64'h0);
        chk("arst_underrun", 64'(o_underrun), 64'h0);
        s_col_valid = 1'b0; i_scroll_en = 1'b0;
        model_reset();
        exp_frame_q.delete();
        exp_ur_q.delete();
        @(negedge aclk);
        areset = 1'b0;
        repeat (3) cycle();
        chk("scoreboard_drained", 64'(exp_frame_q.size()), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/led_place_8x8_scroller.md
Name: led_place_8x8_scroller

Overview:
- Upstream stage of the 8x8 LED matrix scanner; produces the 64-bit frame the scanner consumes on its i_led_data input.
- Accepts column bytes over a valid/ready stream into a small FIFO.
- At a programmable scroll rate, shifts the displayed frame one column left and inserts the next queued column at column 7, giving a marquee effect.

Parameters:
- P_FIFO_DEPTH, 8: column FIFO depth in bytes; power of two, minimum 2.
- P_DIV_WIDTH, 24: width of the scroll-rate divider counter and of i_scroll_div.

Ports:
- aclk  in  1  system clock.
- areset  in  1  asynchronous reset, active-high.
- s_col_data  in  8  column byte; bit r = row r, 1 = LED on.
- s_col_valid  in  1  column byte valid.
- s_col_ready  out  1  FIFO can accept a byte.
- i_scroll_en  in  1  scrolling enabled.
- i_scroll_div  in  P_DIV_WIDTH  scroll period minus 1, in aclk cycles.
- i_clear  in  1  synchronous clear of frame and FIFO.
- o_led_data  out  64  frame; bit (8*row + col) = LED at row, col; drives scanner i_led_data.
- o_frame_update  out  1  one-cycle pulse when o_led_data changed by a scroll step.
- o_fifo_level  out  $clog2(P_FIFO_DEPTH)+1  bytes currently queued.
- o_underrun  out  1  one-cycle pulse when a scroll step found the FIFO empty.

Behaviour:
- Reset (async assert, sync release): o_led_data=0, FIFO empty, o_fifo_level=0, s_col_ready=1, divider=0, o_frame_update=0, o_underrun=0.
- Push handshake:
  - A byte is written when s_col_valid && s_col_ready at a rising aclk edge.
  - s_col_ready = (level < P_FIFO_DEPTH), registered from level.
  - No combinational path from s_col_valid to s_col_ready.
- Divider:
  - While i_scroll_en=1, the counter increments each cycle.
  - When counter == i_scroll_div, it wraps to 0 and asserts the internal tick for one cycle.
  - i_scroll_div=0 gives a tick every cycle.
  - i_scroll_en=0 holds the counter value and suppresses ticks.
  - If i_scroll_div is lowered below the current count, the counter wraps at its full range (2^P_DIV_WIDTH) before ticking.
- Scroll step on tick:
  - New col c = old col c+1 for c = 0..6.
  - New col 7 = FIFO head byte (bit r to o_led_data[8r+7]), and the head is popped.
  - If the FIFO is empty, col 7 = 8'h00, no pop, and o_underrun pulses.
  - o_frame_update pulses the cycle after the tick, aligned with the new o_led_data.
- Latency:
  - A tick at edge N presents new o_led_data after edge N.
  - A byte pushed at edge N is eligible for a tick at edge N+1 or later.
- Simultaneous push and pop:
  - Both complete; level unchanged.
  - When the FIFO is full, a push is not accepted because ready=0, even if a pop occurs in the same cycle.
  - When the FIFO is empty, a push and a tick in the same cycle give an underrun; the pushed byte stays queued.
- i_clear (synchronous):
  - Next cycle: o_led_data=0, FIFO emptied, divider=0.
  - A push in the same cycle is dropped; any tick is discarded; no pulses are emitted.
  - i_clear has priority over push and tick.
- Reset mid-operation: all state returns to reset values immediately; partially queued data is lost.
- FIFO pointers wrap modulo P_FIFO_DEPTH. Level is a separate counter saturating at 0..P_FIFO_DEPTH.

Decomposition:
- Shared package led_place_8x8_pkg holds:
  - LP_ROWS=8, LP_COLS=8, LP_FRAME_W=64.
  - Function frame_bit_idx(row,col)=8*row+col, shared with the scanner.
- One sub-module: led_place_col_fifo, a synchronous FIFO with push/pop, level, full and empty outputs.
- The divider and shift register stay in the top module.

Test Plan:
- Reset, then push 8'hFF with i_scroll_div=3 and i_scroll_en=1 -> first tick on the 4th cycle; o_led_data=64'h8080808080808080; o_frame_update pulses once.
- Push bytes 01,02,04,08,10,20,40,80, then 8 ticks -> o_led_data=64'h8040201008040201 (diagonal); o_underrun never asserted.
- Hold s_col_valid with P_FIFO_DEPTH=8 and scrolling disabled -> exactly 8 accepted; s_col_ready=0; o_fifo_level=8. One tick with valid still high -> level 7, then ready=1; next push restores level 8.
- Empty FIFO, frame=64'hFFFF..FF, one tick -> col 7 cleared (o_led_data=64'h7F7F7F7F7F7F7F7F); o_underrun pulses for 1 cycle.
- i_scroll_en toggled low for 10 cycles mid-count -> tick is delayed by exactly 10 cycles; no extra ticks.
- i_clear asserted together with push and tick, with FIFO level 3 -> next cycle level 0, o_led_data=0, no pulses. Separately, areset mid-scroll -> all outputs at reset values without waiting for a clock edge.
